// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe board decoder.
// Cell codes 1..9 map row-major onto nine one-hot cell enables.
package ttt_pkg;

  localparam int TTT_CELLS  = 9;
  localparam int TTT_CODE_W = 4;

  typedef logic [TTT_CODE_W-1:0] cell_code_t;
  typedef logic [TTT_CELLS-1:0]  cell_mask_t;

  localparam cell_code_t TTT_CODE_NONE = '0;
  localparam cell_code_t TTT_CODE_MAX  = cell_code_t'(TTT_CELLS);

endpackage

// File: rtl/ttt_sync2.sv
// Generic-width two-flop synchronizer, async active-low reset.
// Used on switch inputs when TTT_DECODER_INPUT_SYNC_EN is defined.
module ttt_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_d;
  logic [W-1:0] s1_q;
  logic [W-1:0] s2_d;
  logic [W-1:0] s2_q;

  // Shift the raw input through two stages.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Both stages clear to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ttt_decoder.sv
// Board position decoder: 4-bit cell code to registered one-hot.
// Define TTT_DECODER_INPUT_SYNC_EN to add 2-flop input synchronizers.
module ttt_decoder
  import ttt_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [TTT_CODE_W-1:0] POS_SW,
  input  logic                  ENABLE,
  output logic [TTT_CELLS-1:0]  P_EN,
  output logic                  POS_VALID
);

  cell_code_t code;
  logic       en;

`ifdef TTT_DECODER_INPUT_SYNC_EN
  logic [TTT_CODE_W:0] sync_q;

  ttt_sync2 #(
    .W(TTT_CODE_W + 1)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    ({ENABLE, POS_SW}),
    .q    (sync_q)
  );

  assign en   = sync_q[TTT_CODE_W];
  assign code = sync_q[TTT_CODE_W-1:0];
`else
  assign en   = ENABLE;
  assign code = POS_SW;
`endif

  // The shift index is formed only inside 1..9, so code 0 never wraps.
  function automatic cell_mask_t decode_cell(
    input cell_code_t c,
    input logic       e
  );
    cell_mask_t m;
    m = '0;
    if (e && c != TTT_CODE_NONE && c <= TTT_CODE_MAX)
      m = cell_mask_t'(1) << (c - cell_code_t'(1));
    return m;
  endfunction

  cell_mask_t p_en_d;
  cell_mask_t p_en_q;

  // Decode the current code every cycle; no selection memory.
  always_comb begin
    p_en_d = decode_cell(code, en);
  end

  // Single output register, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) p_en_q <= '0;
    else        p_en_q <= p_en_d;
  end

  assign P_EN      = p_en_q;
  assign POS_VALID = |p_en_q;

endmodule

// File: tb/tb_ttt_decoder.sv
// Scoreboard bench for ttt_decoder, both latency builds.
// Driver queues expected masks by due cycle; monitor checks them.
module tb_ttt_decoder;

`ifdef TTT_DECODER_INPUT_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic       CLK;
  logic       RST_N;
  logic [3:0] POS_SW;
  logic       ENABLE;
  logic [8:0] P_EN;
  logic       POS_VALID;

  ttt_decoder dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .POS_SW   (POS_SW),
    .ENABLE   (ENABLE),
    .P_EN     (P_EN),
    .POS_VALID(POS_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic [8:0] exp;
    string      name;
  } ent_t;

  ent_t q[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string nm,
                       input logic [8:0] act,
                       input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %03h want %03h",
               nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare the entry due in this cycle.
  always @(negedge CLK) begin
    if (RST_N) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s missed: due %0d now %0d",
                 q[0].name, q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        ent_t e;
        e = q.pop_front();
        check({e.name, " p_en"}, P_EN, e.exp);
        check({e.name, " valid"}, {8'h0, POS_VALID},
              {8'h0, (e.exp != 9'h0)});
      end
    end
  end

  // Drive a pair and queue its expected mask for hold cycles.
  task automatic apply(input logic [3:0] sw,
                       input logic en,
                       input logic [8:0] exp,
                       input int hold,
                       input string nm);
    int base;
    POS_SW = sw;
    ENABLE = en;
    base   = cyc;
    for (int i = 0; i < hold; i++) begin
      ent_t e;
      e.due  = base + L + i;
      e.exp  = exp;
      e.name = nm;
      q.push_back(e);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // After reset release the output stays 0 until the pipe fills.
  task automatic push_gap(input string nm);
    for (int i = 1; i < L; i++) begin
      ent_t e;
      e.due  = cyc + i;
      e.exp  = 9'h0;
      e.name = nm;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge CLK);
      #2;
      n++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s drain: %0d left want 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N  = 1'b0;
    POS_SW = 4'd5;
    ENABLE = 1'b1;
    repeat (4) @(posedge CLK);
    #2;
    check("rst p_en", P_EN, 9'h000);
    check("rst valid", {8'h0, POS_VALID}, 9'h000);
    RST_N = 1'b1;
    push_gap("rel gap");
    apply(4'd5, 1'b1, 9'h010, 3, "rel c5");

    for (int s = 0; s <= 9; s++)
      apply(4'(s), 1'b0, 9'h000, 10, "dis sweep");

    apply(4'd1, 1'b1, 9'h001, 3, "en c1");
    apply(4'd2, 1'b1, 9'h002, 3, "en c2");
    apply(4'd3, 1'b1, 9'h004, 3, "en c3");
    apply(4'd4, 1'b1, 9'h008, 3, "en c4");
    apply(4'd5, 1'b1, 9'h010, 3, "en c5");
    apply(4'd6, 1'b1, 9'h020, 3, "en c6");
    apply(4'd7, 1'b1, 9'h040, 3, "en c7");
    apply(4'd8, 1'b1, 9'h080, 3, "en c8");
    apply(4'd9, 1'b1, 9'h100, 3, "en c9");

    apply(4'd0,  1'b1, 9'h000, 4, "inv c0");
    apply(4'd10, 1'b1, 9'h000, 4, "inv c10");
    apply(4'd9,  1'b1, 9'h100, 2, "inv back");
    apply(4'd15, 1'b1, 9'h000, 4, "inv c15");

    apply(4'd3, 1'b1, 9'h004, 4, "tog on");
    apply(4'd3, 1'b0, 9'h000, 4, "tog off");
    apply(4'd3, 1'b1, 9'h004, 4, "tog on2");

    apply(4'd9, 1'b1, 9'h100, 5, "mid pre");
    drain("mid pre");
    check("mid steady", P_EN, 9'h100);
    #1;
    RST_N = 1'b0;
    #1;
    check("mid async p_en", P_EN, 9'h000);
    check("mid async valid", {8'h0, POS_VALID}, 9'h000);
    RST_N = 1'b1;
    push_gap("mid gap");
    apply(4'd9, 1'b1, 9'h100, 4, "mid post");

    drain("end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
